// File: rtl/out_tx.sv
// out_tx: transmit side of the OUT instruction.
// Takes the low byte of the issued GPR operand, buffers it in a FIFO and
// serialises it onto the UART TX line as 8N1, LSB first.
//
// Parameters:
//   CLK_PER_BIT  clocks per serial bit (>= 2)
//   DEPTH_LOG    log2 of FIFO depth
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   issue_valid  OUT instruction issued, operand valid this cycle
//   issue_ready  byte enqueued this cycle (combinational)
//   speculating  branch unresolved; blocks enqueue only
//   data         GPR operand; data[7:0] is transmitted
//   txd          registered UART serial output, idle high
//   tx_empty     FIFO empty and serialiser idle
module out_tx #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        speculating,
  input  logic [31:0] data,
  output logic        txd,
  output logic        tx_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int BW    = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0]      BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [DEPTH_LOG:0] CNT_FULL  = (DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic [BW-1:0]        baud;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic                 push;
  logic                 pop;
  logic                 baud_done;
  logic                 unused_data_hi;

  assign unused_data_hi = ^data[31:8];

  always_comb begin
    issue_ready = issue_valid && !speculating && (count < CNT_FULL);
    push        = issue_ready;
    pop         = (state == IDLE) && (count != '0);
    baud_done   = (baud == BAUD_LAST);
    tx_empty    = (count == '0) && (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // txd is registered, so each transition loads the level of the state being
  // entered; in DATA the next bit is shift[1] because the shift happens on the
  // same edge that drives it out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_tx.sv
// Bench for out_tx: random-gap stimulus, a queue-based frame model checked on
// every cycle, a UART decoder on txd, and literal waveform pins.
module tb_out_tx;

  localparam int CPB   = 4;
  localparam int DLOG  = 2;
  localparam int DEPTH = 1 << DLOG;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid;
  logic        issue_ready;
  logic        speculating;
  logic [31:0] data;
  logic        txd;
  logic        tx_empty;

  int checks = 0;
  int errors = 0;

  out_tx #(.CLK_PER_BIT(CPB), .DEPTH_LOG(DLOG)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .speculating (speculating),
    .data        (data),
    .txd         (txd),
    .tx_empty    (tx_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of accepted bytes plus the position t within the frame being sent.
  logic [7:0] mq[$];
  bit         m_busy;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_push;
  logic [7:0] m_d;

  function automatic logic exp_ready();
    return issue_valid && !speculating && (mq.size() < DEPTH);
  endfunction

  function automatic logic exp_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_busy = 0;
      m_t    = 0;
    end else begin
      m_push = exp_ready();
      m_d    = data[7:0];
      if (m_busy) begin
        m_t++;
        if (m_t == 10 * CPB) m_busy = 0;
      end else if (mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_busy = 1;
        m_t    = 0;
      end
      if (m_push) mq.push_back(m_d);
    end
  end

  always @(negedge clk) begin
    chk("model_ready", issue_ready, exp_ready());
    chk("model_txd", txd, exp_txd());
    chk("model_empty", tx_empty, (!m_busy && mq.size() == 0));
  end

  // ---------------- UART decoder ----------------
  logic [7:0] rxq[$];
  logic [7:0] rb;
  bit         rx_ok;

  initial forever begin
    @(negedge clk);
    if (rstn === 1'b1 && txd === 1'b0) begin
      rx_ok = 1;
      repeat (CPB / 2) begin @(negedge clk); if (rstn !== 1'b1) rx_ok = 0; end
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) begin @(negedge clk); if (rstn !== 1'b1) rx_ok = 0; end
        rb[i] = txd;
      end
      repeat (CPB) begin @(negedge clk); if (rstn !== 1'b1) rx_ok = 0; end
      if (rx_ok) begin
        chk("stop_bit", txd, 1'b1);
        rxq.push_back(rb);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_byte(input logic [7:0] b);
    int n = 0;
    issue_valid = 1'b1;
    data = $urandom();
    data[7:0] = b;
    while (1) begin
      @(negedge clk);
      if (issue_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL issue_wait: ready never rose for byte %0h", b);
        break;
      end
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (tx_empty !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL drain: tx_empty stuck at %0b", tx_empty);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input logic [7:0] first, input int n);
    chk("rx_count", rxq.size(), n);
    for (int i = 0; i < n && i < rxq.size(); i++)
      chk("rx_byte", rxq[i], first + 8'(i));
    rxq.delete();
  endtask

  // ---------------- test sequence ----------------
  logic [9:0] frame_a5;
  int gap;

  initial begin
    rstn = 1'b0; issue_valid = 1'b0; speculating = 1'b0; data = '0;

    // reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst_txd", txd, 1'b1);
      chk("rst_empty", tx_empty, 1'b1);
      chk("rst_ready", issue_ready, 1'b0);
    end
    @(posedge clk); #1; rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // single byte, literal waveform: stop, A5 LSB first, start
    frame_a5 = {1'b1, 8'hA5, 1'b0};
    issue_valid = 1'b1; data = 32'h1234_56A5;
    @(negedge clk);
    chk("single_ready", issue_ready, 1'b1);
    @(posedge clk); #1; issue_valid = 1'b0;
    @(negedge clk);
    chk("latency_txd_high", txd, 1'b1);
    chk("latency_not_empty", tx_empty, 1'b0);
    for (int k = 0; k < 10; k++)
      repeat (CPB) begin @(negedge clk); chk("frame_a5", txd, frame_a5[k]); end
    @(negedge clk);
    chk("single_empty_after", tx_empty, 1'b1);
    drain();
    check_rx(8'hA5, 1);

    // speculation blocks enqueue
    issue_valid = 1'b1; speculating = 1'b1; data = 32'hFFFF_FF5A;
    repeat (5) begin
      @(negedge clk);
      chk("spec_ready", issue_ready, 1'b0);
      chk("spec_txd", txd, 1'b1);
    end
    @(posedge clk); #1; speculating = 1'b0;
    @(negedge clk);
    chk("spec_release_ready", issue_ready, 1'b1);
    @(posedge clk); #1; issue_valid = 1'b0;
    drain();
    check_rx(8'h5A, 1);

    // full FIFO back-pressure
    for (int i = 1; i <= 6; i++) issue_byte(8'(i));
    drain();
    check_rx(8'h01, 6);

    // pointer wrap with random gaps
    for (int i = 0; i < 12; i++) begin
      issue_byte(8'h10 + 8'(i));
      gap = $urandom_range(0, 6);
      repeat (gap) @(posedge clk);
      #1;
    end
    drain();
    check_rx(8'h10, 12);

    // reset in the middle of DATA bit 3, with bytes still queued
    issue_byte(8'h77);
    issue_byte(8'h88);
    issue_byte(8'h99);
    repeat (16) @(posedge clk);
    #1; rstn = 1'b0;
    #1;
    chk("midrst_txd", txd, 1'b1);
    chk("midrst_empty", tx_empty, 1'b1);
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    rxq.delete();
    issue_byte(8'h3C);
    drain();
    check_rx(8'h3C, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
